multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bundle between the multicycle FSM (master) and its datapath/memory side (slave).
// Carries the decoded instruction fields, the memory and mul/div handshakes, and every control select/strobe.
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic       funct7b0;
  logic       mem_ready;
  logic       muldiv_ready;
  logic       take_branch;

  logic       mem_valid;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic       reg_write;
  logic       instret_inc;
  logic       muldiv_valid;
  logic       illegal;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] result_src;
  logic [4:0] state_o;

  modport master (
    input  op, funct7b0, mem_ready, muldiv_ready, take_branch,
    output mem_valid, mem_we, ir_we, pc_we, reg_write, instret_inc, muldiv_valid,
           illegal, adr_src, alu_src_a, alu_src_b, alu_op, result_src, state_o
  );

  modport slave (
    output op, funct7b0, mem_ready, muldiv_ready, take_branch,
    input  mem_valid, mem_we, ir_we, pc_we, reg_write, instret_inc, muldiv_valid,
           illegal, adr_src, alu_src_a, alu_src_b, alu_op, result_src, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// All selects decode from state alone; strobes are qualified by mem_ready, muldiv_ready or take_branch.
module multicycle_control_fsm #(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  multicycle_control_fsm_if.master      bus
);

  localparam logic [4:0] FETCH    = 5'd0;
  localparam logic [4:0] DECODE   = 5'd1;
  localparam logic [4:0] MEMADR   = 5'd2;
  localparam logic [4:0] MEMREAD  = 5'd3;
  localparam logic [4:0] MEMWB    = 5'd4;
  localparam logic [4:0] MEMWRITE = 5'd5;
  localparam logic [4:0] EXECUTER = 5'd6;
  localparam logic [4:0] EXECUTEI = 5'd7;
  localparam logic [4:0] ALUWB    = 5'd8;
  localparam logic [4:0] BRANCH   = 5'd9;
  localparam logic [4:0] JAL      = 5'd10;
  localparam logic [4:0] JALRCALC = 5'd11;
  localparam logic [4:0] LUI      = 5'd12;
  localparam logic [4:0] AUIPC    = 5'd13;
  localparam logic [4:0] MULDIV   = 5'd14;
  localparam logic [4:0] SYSTEM   = 5'd15;
  localparam logic [4:0] ILLEGAL  = 5'd16;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [4:0] state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R: begin
            if (!bus.funct7b0)  state_d = EXECUTER;
            else if (MULDIV_EN) state_d = MULDIV;
            else                state_d = ILLEGAL;
          end
          OP_I:      state_d = EXECUTEI;
          OP_JAL:    state_d = JAL;
          OP_JALR:   state_d = JALRCALC;
          OP_BRANCH: state_d = BRANCH;
          OP_LUI:    state_d = LUI;
          OP_AUIPC:  state_d = AUIPC;
          OP_SYSTEM: state_d = SYSTEM;
          default:   state_d = ILLEGAL;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      EXECUTER, EXECUTEI, LUI, AUIPC: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JALRCALC: state_d = JAL;
      JAL:      state_d = ALUWB;
      MULDIV:   if (bus.muldiv_ready) state_d = FETCH;
      SYSTEM:   state_d = FETCH;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = ILLEGAL;
    endcase
  end

  // Outputs are forced low while rst is high so an in-flight memory request is withdrawn at once.
  always_comb begin
    bus.mem_valid    = 1'b0;
    bus.mem_we       = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.reg_write    = 1'b0;
    bus.instret_inc  = 1'b0;
    bus.muldiv_valid = 1'b0;
    bus.illegal      = 1'b0;
    bus.adr_src      = 1'b0;
    bus.alu_src_a    = 2'd0;
    bus.alu_src_b    = 2'd0;
    bus.alu_op       = 2'd0;
    bus.result_src   = 3'd0;
    bus.state_o      = state_q;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.mem_valid  = 1'b1;
          bus.alu_src_b  = 2'd2;
          bus.result_src = 3'd2;
          bus.ir_we      = bus.mem_ready;
          bus.pc_we      = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd1;
        end
        MEMADR, JALRCALC: begin
          bus.alu_src_a = 2'd2;
          bus.alu_src_b = 2'd1;
        end
        MEMREAD: begin
          bus.mem_valid = 1'b1;
          bus.adr_src   = 1'b1;
        end
        MEMWB: begin
          bus.result_src  = 3'd1;
          bus.reg_write   = 1'b1;
          bus.instret_inc = 1'b1;
        end
        MEMWRITE: begin
          bus.mem_valid   = 1'b1;
          bus.mem_we      = 1'b1;
          bus.adr_src     = 1'b1;
          bus.instret_inc = bus.mem_ready;
        end
        EXECUTER: begin
          bus.alu_src_a = 2'd2;
          bus.alu_op    = 2'd2;
        end
        EXECUTEI: begin
          bus.alu_src_a = 2'd2;
          bus.alu_src_b = 2'd1;
          bus.alu_op    = 2'd2;
        end
        ALUWB: begin
          bus.reg_write   = 1'b1;
          bus.instret_inc = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a   = 2'd2;
          bus.alu_op      = 2'd1;
          bus.pc_we       = bus.take_branch;
          bus.instret_inc = 1'b1;
        end
        JAL: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd2;
          bus.pc_we     = 1'b1;
        end
        LUI: begin
          bus.alu_src_b = 2'd1;
          bus.alu_op    = 2'd3;
        end
        AUIPC: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd1;
        end
        MULDIV: begin
          bus.muldiv_valid = 1'b1;
          bus.result_src   = 3'd4;
          bus.reg_write    = bus.muldiv_ready;
          bus.instret_inc  = bus.muldiv_ready;
        end
        SYSTEM: begin
          bus.result_src  = 3'd3;
          bus.reg_write   = 1'b1;
          bus.instret_inc = 1'b1;
        end
        ILLEGAL:  bus.illegal = 1'b1;
        default:  bus.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: each instruction is expanded into the cycle-by-cycle
// state/output trace it should produce, then replayed against the DUT while outputs are compared.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm_if bus0 ();

  multicycle_control_fsm #(.MULDIV_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  multicycle_control_fsm #(.MULDIV_EN(1'b0)) dut_nomd (.clk(clk), .rst(rst), .bus(bus0));

  assign bus0.op           = bus.op;
  assign bus0.funct7b0     = bus.funct7b0;
  assign bus0.mem_ready    = bus.mem_ready;
  assign bus0.muldiv_ready = bus.muldiv_ready;
  assign bus0.take_branch  = bus.take_branch;

  typedef struct packed {
    logic [4:0] st;
    logic       mem_valid, mem_we, ir_we, pc_we, reg_write, instret_inc, muldiv_valid, illegal, adr_src;
    logic [1:0] a, b, aop;
    logic [2:0] rs;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic       f7, mr, mdr, tbr;
    out_t       exp;
  } cyc_t;

  // Instruction classes driven through the bench.
  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5, K_JALR = 6;
  localparam int K_LUI = 7, K_AUIPC = 8, K_SYS = 9, K_MUL = 10, K_BADOP = 11, K_MUL_NOMD = 12;

  out_t obs, obs0;
  assign obs  = {bus.state_o, bus.mem_valid, bus.mem_we, bus.ir_we, bus.pc_we, bus.reg_write,
                 bus.instret_inc, bus.muldiv_valid, bus.illegal, bus.adr_src,
                 bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src};
  assign obs0 = {bus0.state_o, bus0.mem_valid, bus0.mem_we, bus0.ir_we, bus0.pc_we, bus0.reg_write,
                 bus0.instret_inc, bus0.muldiv_valid, bus0.illegal, bus0.adr_src,
                 bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.result_src};

  cyc_t q[$];
  int   vecCount  = 0;
  int   failCount = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t idle(input int st);
    out_t o;
    o    = '0;
    o.st = 5'(st);
    return o;
  endfunction

  function automatic logic knownOp(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                      7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1110011};
  endfunction

  function automatic logic [6:0] opOf(input int kind);
    logic [6:0] r;
    case (kind)
      K_R, K_MUL, K_MUL_NOMD: r = 7'b0110011;
      K_I:     r = 7'b0010011;
      K_LOAD:  r = 7'b0000011;
      K_STORE: r = 7'b0100011;
      K_BR:    r = 7'b1100011;
      K_JAL:   r = 7'b1101111;
      K_JALR:  r = 7'b1100111;
      K_LUI:   r = 7'b0110111;
      K_AUIPC: r = 7'b0010111;
      K_SYS:   r = 7'b1110011;
      default: begin
        r = 7'($urandom_range(0, 127));
        while (knownOp(r)) r = 7'($urandom_range(0, 127));
      end
    endcase
    return r;
  endfunction

  task automatic push(input logic [6:0] op, input logic f7, input out_t e);
    cyc_t c;
    c.op  = op;
    c.f7  = f7;
    c.mr  = rbit();
    c.mdr = rbit();
    c.tbr = rbit();
    c.exp = e;
    q.push_back(c);
  endtask

  task automatic pushWb(input logic [6:0] op, input logic f7);
    out_t e;
    e = idle(8); e.reg_write = 1'b1; e.instret_inc = 1'b1;
    push(op, f7, e);
  endtask

  // Expands one instruction into its expected trace; fw/mw are the wait cycles before the ready handshakes.
  task automatic addInstr(input int kind, input int fw, input int mw, input logic tbr);
    logic [6:0] op;
    logic       f7;
    out_t       e;
    op = opOf(kind);
    f7 = (kind == K_R) ? 1'b0 : (kind == K_MUL || kind == K_MUL_NOMD) ? 1'b1 : rbit();
    for (int i = 0; i <= fw; i++) begin
      e = idle(0); e.mem_valid = 1'b1; e.b = 2'd2; e.rs = 3'd2;
      e.ir_we = (i == fw); e.pc_we = (i == fw);
      push(op, f7, e);
      q[$].mr = (i == fw);
    end
    e = idle(1); e.a = 2'd1; e.b = 2'd1;
    push(op, f7, e);
    case (kind)
      K_R:     begin e = idle(6);  e.a = 2'd2; e.aop = 2'd2; push(op, f7, e); pushWb(op, f7); end
      K_I:     begin e = idle(7);  e.a = 2'd2; e.b = 2'd1; e.aop = 2'd2; push(op, f7, e); pushWb(op, f7); end
      K_LUI:   begin e = idle(12); e.b = 2'd1; e.aop = 2'd3; push(op, f7, e); pushWb(op, f7); end
      K_AUIPC: begin e = idle(13); e.a = 2'd1; e.b = 2'd1; push(op, f7, e); pushWb(op, f7); end
      K_LOAD, K_STORE: begin
        e = idle(2); e.a = 2'd2; e.b = 2'd1;
        push(op, f7, e);
        for (int i = 0; i <= mw; i++) begin
          e = idle(kind == K_LOAD ? 3 : 5); e.mem_valid = 1'b1; e.adr_src = 1'b1;
          if (kind == K_STORE) begin e.mem_we = 1'b1; e.instret_inc = (i == mw); end
          push(op, f7, e);
          q[$].mr = (i == mw);
        end
        if (kind == K_LOAD) begin
          e = idle(4); e.rs = 3'd1; e.reg_write = 1'b1; e.instret_inc = 1'b1;
          push(op, f7, e);
        end
      end
      K_BR: begin
        e = idle(9); e.a = 2'd2; e.aop = 2'd1; e.pc_we = tbr; e.instret_inc = 1'b1;
        push(op, f7, e);
        q[$].tbr = tbr;
      end
      K_JAL, K_JALR: begin
        if (kind == K_JALR) begin e = idle(11); e.a = 2'd2; e.b = 2'd1; push(op, f7, e); end
        e = idle(10); e.a = 2'd1; e.b = 2'd2; e.pc_we = 1'b1;
        push(op, f7, e);
        pushWb(op, f7);
      end
      K_SYS: begin
        e = idle(15); e.rs = 3'd3; e.reg_write = 1'b1; e.instret_inc = 1'b1;
        push(op, f7, e);
      end
      K_MUL: begin
        for (int i = 0; i <= mw; i++) begin
          e = idle(14); e.muldiv_valid = 1'b1; e.rs = 3'd4;
          e.reg_write = (i == mw); e.instret_inc = (i == mw);
          push(op, f7, e);
          q[$].mdr = (i == mw);
        end
      end
      default: begin
        for (int i = 0; i < mw; i++) begin
          e = idle(16); e.illegal = 1'b1;
          push(op, f7, e);
        end
      end
    endcase
  endtask

  task automatic checkOutput(input string tag, input out_t observed, input out_t expected);
    vecCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
    end
  endtask

  // Entered just after a rising edge: drive inputs, compare on the falling edge, return after the next rise.
  task automatic applyStimulus(input cyc_t c, input bit useNoMd);
    bus.op           = c.op;
    bus.funct7b0     = c.f7;
    bus.mem_ready    = c.mr;
    bus.muldiv_ready = c.mdr;
    bus.take_branch  = c.tbr;
    @(negedge clk);
    checkOutput($sformatf("%s_st%0d", useNoMd ? "nomd" : "dut", c.exp.st), useNoMd ? obs0 : obs, c.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic runQueue(input int n, input bit useNoMd);
    int left;
    left = n;
    while (q.size() > 0 && left != 0) begin
      applyStimulus(q.pop_front(), useNoMd);
      left--;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.muldiv_ready = 1'b1;
    bus.take_branch = 1'b1;
    #1;
    checkOutput("reset", obs, idle(0));
    checkOutput("reset_nomd", obs0, idle(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.op = '0;
    bus.funct7b0 = 1'b0;
    bus.mem_ready = 1'b0;
    bus.muldiv_ready = 1'b0;
    bus.take_branch = 1'b0;
    rst = 1'b1;
    #1;
    doReset();

    addInstr(K_R, 1, 0, 1'b0);
    addInstr(K_LOAD, 0, 3, 1'b0);
    addInstr(K_BR, 0, 0, 1'b0);
    addInstr(K_BR, 2, 0, 1'b1);
    addInstr(K_JALR, 0, 0, 1'b0);
    addInstr(K_MUL, 0, 33, 1'b0);
    addInstr(K_STORE, 1, 2, 1'b0);
    runQueue(-1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 10);
      addInstr(kind, $urandom_range(0, 3),
               (kind == K_MUL) ? $urandom_range(0, 40) : $urandom_range(0, 4), rbit());
      runQueue(-1, 1'b0);
    end

    addInstr(K_STORE, 0, 12, 1'b0);
    runQueue(6, 1'b0);
    bus.mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_write", obs, idle(0));
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    addInstr(K_I, 1, 0, 1'b0);
    runQueue(-1, 1'b0);

    addInstr(K_BADOP, $urandom_range(0, 2), 6, 1'b0);
    runQueue(-1, 1'b0);

    doReset();
    addInstr(K_MUL_NOMD, 1, 8, 1'b0);
    runQueue(-1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
